// File: rtl/crop_pkg.sv
// Shared types and constants for the crop scheduler slice:
// FSM states, default frame geometry, per-pass pixel totals and
// the stored crop origin.
package crop_pkg;

    localparam int ROW_W = 10;
    localparam int COL_W = 10;

    localparam int IN_ROWS_D  = 100;
    localparam int IN_COLS_D  = 160;
    localparam int OUT_ROWS_D = 48;
    localparam int OUT_COLS_D = 48;

    // Pixels crossing each side of crop_filter in one complete pass
    localparam int IN_PIX  = IN_ROWS_D * IN_COLS_D;
    localparam int OUT_PIX = OUT_ROWS_D * OUT_COLS_D;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_NEXT
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] y1;
        logic [COL_W-1:0] x1;
    } coord_t;

endpackage

// File: rtl/crop_scheduler_if.sv
// Stream bundle between the scheduler, its config source and the
// crop_filter coordinate inputs. The master side is the scheduler.
interface crop_scheduler_if #(
    parameter int Y_W = 10,
    parameter int X_W = 10
);
    logic [Y_W+X_W-1:0] cfg_TDATA;
    logic               cfg_TVALID;
    logic               cfg_TREADY;

    logic [Y_W-1:0]     crop_Y1_TDATA;
    logic               crop_Y1_TVALID;
    logic               crop_Y1_TREADY;

    logic [X_W-1:0]     crop_X1_TDATA;
    logic               crop_X1_TVALID;
    logic               crop_X1_TREADY;

    modport master (
        input  cfg_TDATA, cfg_TVALID, crop_Y1_TREADY, crop_X1_TREADY,
        output cfg_TREADY, crop_Y1_TDATA, crop_Y1_TVALID,
               crop_X1_TDATA, crop_X1_TVALID
    );

    modport slave (
        output cfg_TDATA, cfg_TVALID, crop_Y1_TREADY, crop_X1_TREADY,
        input  cfg_TREADY, crop_Y1_TDATA, crop_Y1_TVALID,
               crop_X1_TDATA, crop_X1_TVALID
    );
endinterface

// File: rtl/crop_coord_table.sv
// Crop origin table: accepts NUM_CROPS coordinates from the config
// stream, clamps each so the crop window stays inside the frame, and
// serves one entry to the scheduler through a combinational read port.
module crop_coord_table
    import crop_pkg::*;
#(
    parameter int IN_ROWS   = IN_ROWS_D,
    parameter int IN_COLS   = IN_COLS_D,
    parameter int OUT_ROWS  = OUT_ROWS_D,
    parameter int OUT_COLS  = OUT_COLS_D,
    parameter int NUM_CROPS = 3,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  coord_t           cfg_coord,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             last_write,
    output logic             cfg_err,
    input  logic [IDX_W-1:0] rd_idx,
    output coord_t           rd_coord
);

    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(IN_ROWS - OUT_ROWS);
    localparam logic [COL_W-1:0] X_MAX = COL_W'(IN_COLS - OUT_COLS);

    coord_t           tbl [NUM_CROPS];
    coord_t           clamped;
    logic             clipped;
    logic             fire;
    logic             full;
    logic [IDX_W-1:0] ptr;

    assign fire       = cfg_ready & cfg_valid;
    assign last_write = fire & (ptr == IDX_W'(NUM_CROPS - 1));
    assign rd_coord   = tbl[rd_idx];

    // Pull out-of-range origins back to the last legal position and flag it
    always_comb begin
        clamped = cfg_coord;
        clipped = 1'b0;
        if (cfg_coord.y1 > Y_MAX) begin
            clamped.y1 = Y_MAX;
            clipped    = 1'b1;
        end
        if (cfg_coord.x1 > X_MAX) begin
            clamped.x1 = X_MAX;
            clipped    = 1'b1;
        end
    end

    // Write pointer, fill status, ready and sticky clamp flag; only reset empties the table
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            full      <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= ~full & ~last_write;
            if (fire) begin
                if (clipped)
                    cfg_err <= 1'b1;
                if (last_write)
                    full <= 1'b1;
                else
                    ptr <= ptr + IDX_W'(1);
            end
        end
    end

    // Table storage carries no reset; entries are meaningless until reloaded
    always_ff @(posedge clk) begin
        if (fire)
            tbl[ptr] <= clamped;
    end

endmodule

// File: rtl/crop_scheduler.sv
// Walks crop_filter through the coordinate table: issues each origin on
// the Y1/X1 streams, counts pixel handshakes until the pass is complete,
// then moves on to the next entry.
module crop_scheduler
    import crop_pkg::*;
#(
    parameter int IN_ROWS          = IN_ROWS_D,
    parameter int IN_COLS          = IN_COLS_D,
    parameter int OUT_ROWS         = OUT_ROWS_D,
    parameter int OUT_COLS         = OUT_COLS_D,
    parameter int IMG_ROW_BITWIDTH = ROW_W,
    parameter int IMG_COL_BITWIDTH = COL_W,
    parameter int NUM_CROPS        = 3,
    localparam int IDX_W           = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    crop_scheduler_if.master       bus,
    input  logic                   start,
    input  logic                   pix_in_fire,
    input  logic                   pix_out_fire,
    output logic [IDX_W-1:0]       crop_idx,
    output logic                   crop_done,
    output logic                   all_done,
    output logic                   busy,
    output logic                   cfg_err
);

    localparam int IN_MAX  = IN_ROWS * IN_COLS;
    localparam int OUT_MAX = OUT_ROWS * OUT_COLS;
    localparam int IN_CW   = $clog2(IN_MAX + 1);
    localparam int OUT_CW  = $clog2(OUT_MAX + 1);

    state_t            state;
    coord_t            cfg_coord;
    coord_t            rd_coord;
    logic [IDX_W-1:0]  rd_idx;
    logic              last_write;
    logic [IN_CW-1:0]  in_cnt, in_next;
    logic [OUT_CW-1:0] out_cnt, out_next;
    logic              y_clear, x_clear;

    crop_coord_table #(
        .IN_ROWS   (IN_ROWS),
        .IN_COLS   (IN_COLS),
        .OUT_ROWS  (OUT_ROWS),
        .OUT_COLS  (OUT_COLS),
        .NUM_CROPS (NUM_CROPS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .cfg_coord  (cfg_coord),
        .cfg_valid  (bus.cfg_TVALID),
        .cfg_ready  (bus.cfg_TREADY),
        .last_write (last_write),
        .cfg_err    (cfg_err),
        .rd_idx     (rd_idx),
        .rd_coord   (rd_coord)
    );

    // Each stream is finished once its valid is down or is being accepted now
    assign y_clear = ~bus.crop_Y1_TVALID | bus.crop_Y1_TREADY;
    assign x_clear = ~bus.crop_X1_TVALID | bus.crop_X1_TREADY;

    // Split the config word, look up the entry about to be issued, and form saturating counts
    always_comb begin
        cfg_coord    = '0;
        cfg_coord.y1 = bus.cfg_TDATA[IMG_COL_BITWIDTH +: IMG_ROW_BITWIDTH];
        cfg_coord.x1 = bus.cfg_TDATA[IMG_COL_BITWIDTH-1:0];
        rd_idx       = (state == ST_NEXT) ? crop_idx + IDX_W'(1) : '0;
        in_next      = in_cnt;
        out_next     = out_cnt;
        if (pix_in_fire && in_cnt != IN_CW'(IN_MAX))
            in_next = in_cnt + IN_CW'(1);
        if (pix_out_fire && out_cnt != OUT_CW'(OUT_MAX))
            out_next = out_cnt + OUT_CW'(1);
    end

    // Pass sequencer; counters are cleared on entry to ISSUE so fires seen while
    // the coordinates are still being accepted already count toward the pass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ST_LOAD;
            crop_idx           <= '0;
            in_cnt             <= '0;
            out_cnt            <= '0;
            crop_done          <= 1'b0;
            all_done           <= 1'b0;
            busy               <= 1'b0;
            bus.crop_Y1_TDATA  <= '0;
            bus.crop_Y1_TVALID <= 1'b0;
            bus.crop_X1_TDATA  <= '0;
            bus.crop_X1_TVALID <= 1'b0;
        end else begin
            crop_done <= 1'b0;
            all_done  <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (last_write)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (start) begin
                        state              <= ST_ISSUE;
                        crop_idx           <= '0;
                        busy               <= 1'b1;
                        in_cnt             <= '0;
                        out_cnt            <= '0;
                        bus.crop_Y1_TDATA  <= rd_coord.y1;
                        bus.crop_X1_TDATA  <= rd_coord.x1;
                        bus.crop_Y1_TVALID <= 1'b1;
                        bus.crop_X1_TVALID <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    in_cnt  <= in_next;
                    out_cnt <= out_next;
                    if (bus.crop_Y1_TREADY)
                        bus.crop_Y1_TVALID <= 1'b0;
                    if (bus.crop_X1_TREADY)
                        bus.crop_X1_TVALID <= 1'b0;
                    if (y_clear && x_clear)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    in_cnt  <= in_next;
                    out_cnt <= out_next;
                    if (in_next == IN_CW'(IN_MAX) && out_next == OUT_CW'(OUT_MAX)) begin
                        crop_done <= 1'b1;
                        state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (crop_idx == IDX_W'(NUM_CROPS - 1)) begin
                        all_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        state              <= ST_ISSUE;
                        crop_idx           <= crop_idx + IDX_W'(1);
                        in_cnt             <= '0;
                        out_cnt            <= '0;
                        bus.crop_Y1_TDATA  <= rd_coord.y1;
                        bus.crop_X1_TDATA  <= rd_coord.x1;
                        bus.crop_Y1_TVALID <= 1'b1;
                        bus.crop_X1_TVALID <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_crop_scheduler.sv
// Directed bench for crop_scheduler: a three-entry instance runs the
// full table, and a single-entry instance exercises clamping.
module tb_crop_scheduler;
    import crop_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset1;
    logic       start, start1;
    logic       pix_in_fire, pix_out_fire, pin1, pout1;
    logic [1:0] crop_idx;
    logic [0:0] crop_idx1;
    logic       crop_done, all_done, busy, cfg_err;
    logic       crop_done1, all_done1, busy1, cfg_err1;

    crop_scheduler_if #(.Y_W(10), .X_W(10)) bus0 ();
    crop_scheduler_if #(.Y_W(10), .X_W(10)) bus1 ();

    crop_scheduler #(.NUM_CROPS(3)) dut (
        .clk(clk), .reset(reset), .bus(bus0), .start(start),
        .pix_in_fire(pix_in_fire), .pix_out_fire(pix_out_fire),
        .crop_idx(crop_idx), .crop_done(crop_done), .all_done(all_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    crop_scheduler #(.NUM_CROPS(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(bus1), .start(start1),
        .pix_in_fire(pin1), .pix_out_fire(pout1),
        .crop_idx(crop_idx1), .crop_done(crop_done1), .all_done(all_done1),
        .busy(busy1), .cfg_err(cfg_err1)
    );

    int total = 0;
    int bad   = 0;
    int doneCount = 0;
    int allCount  = 0;
    logic [9:0] yLog[$];
    logic [9:0] xLog[$];

    // Record accepted coordinates and completion pulses of the main instance
    always @(posedge clk) begin
        if (bus0.crop_Y1_TVALID && bus0.crop_Y1_TREADY) yLog.push_back(bus0.crop_Y1_TDATA);
        if (bus0.crop_X1_TVALID && bus0.crop_X1_TREADY) xLog.push_back(bus0.crop_X1_TDATA);
        if (crop_done) doneCount++;
        if (all_done)  allCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic inF, input logic outF);
        pix_in_fire  = inF;
        pix_out_fire = outF;
        tick();
        pix_in_fire  = 1'b0;
        pix_out_fire = 1'b0;
    endtask

    task automatic loadCoord(input logic [9:0] y, input logic [9:0] x);
        int w = 0;
        bus0.cfg_TDATA  = {y, x};
        bus0.cfg_TVALID = 1'b1;
        while (!bus0.cfg_TREADY && w < 20) begin
            tick();
            w++;
        end
        checkOutput("cfg_ready_wait", 32'(w < 20), 1);
        tick();
        bus0.cfg_TVALID = 1'b0;
    endtask

    // Run the current pass with both pixel streams firing every cycle
    task automatic runPass(input string tag, output int n);
        logic got = 1'b0;
        n = 0;
        while (!got && n < 17000) begin
            applyStimulus(1'b1, 1'b1);
            n++;
            if (crop_done) got = 1'b1;
        end
        checkOutput(tag, 32'(got), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cfg_ready"}, 32'(bus0.cfg_TREADY), 0);
        checkOutput({tag, "_y_valid"},   32'(bus0.crop_Y1_TVALID), 0);
        checkOutput({tag, "_x_valid"},   32'(bus0.crop_X1_TVALID), 0);
        checkOutput({tag, "_idx"},       32'(crop_idx), 0);
        checkOutput({tag, "_busy"},      32'(busy), 0);
        checkOutput({tag, "_err"},       32'(cfg_err), 0);
        checkOutput({tag, "_pulses"},    32'({crop_done, all_done}), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic got;
        logic [9:0] expY [3] = '{10'd0, 10'd37, 10'd52};
        logic [9:0] expX [3] = '{10'd0, 10'd59, 10'd112};

        reset = 0; reset1 = 0; start = 0; start1 = 0;
        pix_in_fire = 0; pix_out_fire = 0; pin1 = 0; pout1 = 0;
        bus0.cfg_TDATA = '0; bus0.cfg_TVALID = 0; bus0.crop_Y1_TREADY = 0; bus0.crop_X1_TREADY = 0;
        bus1.cfg_TDATA = '0; bus1.cfg_TVALID = 0; bus1.crop_Y1_TREADY = 0; bus1.crop_X1_TREADY = 0;
        tick(); tick();
        checkAllZero("rst");

        // Table load, with a start pulse that must be ignored in LOAD
        reset = 1;
        tick();
        checkOutput("load_ready", 32'(bus0.cfg_TREADY), 1);
        loadCoord(10'd0, 10'd0);
        start = 1; tick(); start = 0; tick();
        checkOutput("load_start_busy", 32'(busy), 0);
        checkOutput("load_start_valid", 32'(bus0.crop_Y1_TVALID), 0);
        checkOutput("load_still_ready", 32'(bus0.cfg_TREADY), 1);
        loadCoord(10'd37, 10'd59);
        loadCoord(10'd52, 10'd112);
        checkOutput("idle_ready", 32'(bus0.cfg_TREADY), 0);
        bus0.cfg_TDATA = {10'd9, 10'd9}; bus0.cfg_TVALID = 1; tick(); bus0.cfg_TVALID = 0;
        checkOutput("idle_cfg_ignored", 32'(bus0.cfg_TREADY), 0);

        // First pass: exact pixel totals around the completion boundary
        start = 1; tick(); start = 0;
        checkOutput("c0_y_valid", 32'(bus0.crop_Y1_TVALID), 1);
        checkOutput("c0_x_valid", 32'(bus0.crop_X1_TVALID), 1);
        checkOutput("c0_busy", 32'(busy), 1);
        checkOutput("c0_idx", 32'(crop_idx), 0);
        checkOutput("c0_y_data", 32'(bus0.crop_Y1_TDATA), 0);
        checkOutput("c0_x_data", 32'(bus0.crop_X1_TDATA), 0);
        bus0.crop_Y1_TREADY = 1; bus0.crop_X1_TREADY = 1; tick();
        bus0.crop_Y1_TREADY = 0; bus0.crop_X1_TREADY = 0;
        checkOutput("c0_y_dropped", 32'(bus0.crop_Y1_TVALID), 0);
        checkOutput("c0_x_dropped", 32'(bus0.crop_X1_TVALID), 0);
        for (int i = 0; i < IN_PIX; i++) applyStimulus(1'b1, i < OUT_PIX - 1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c0_no_done_short", 32'(doneCount), 0);
        checkOutput("c0_busy_run", 32'(busy), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("c0_done_pulse", 32'(crop_done), 1);
        checkOutput("c0_done_idx", 32'(crop_idx), 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c1_done_cleared", 32'(crop_done), 0);
        checkOutput("c1_idx", 32'(crop_idx), 1);
        checkOutput("c1_y_valid", 32'(bus0.crop_Y1_TVALID), 1);
        checkOutput("c1_x_valid", 32'(bus0.crop_X1_TVALID), 1);
        checkOutput("c1_y_data", 32'(bus0.crop_Y1_TDATA), 37);
        checkOutput("c1_x_data", 32'(bus0.crop_X1_TDATA), 59);

        // Second pass: X1 held off while Y1 completes, then a start pulse in RUN
        bus0.crop_Y1_TREADY = 1; tick(); bus0.crop_Y1_TREADY = 0;
        checkOutput("c1_y_first", 32'(bus0.crop_Y1_TVALID), 0);
        checkOutput("c1_x_held", 32'(bus0.crop_X1_TVALID), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("c1_x_stall_valid", 32'(bus0.crop_X1_TVALID), 1);
            checkOutput("c1_x_stall_data", 32'(bus0.crop_X1_TDATA), 59);
            checkOutput("c1_y_stall_valid", 32'(bus0.crop_Y1_TVALID), 0);
        end
        bus0.crop_X1_TREADY = 1; tick(); bus0.crop_X1_TREADY = 0;
        checkOutput("c1_x_done", 32'(bus0.crop_X1_TVALID), 0);
        start = 1; tick(); start = 0;
        checkOutput("c1_start_ignored", 32'(crop_idx), 1);
        runPass("c1_done_seen", n);
        checkOutput("c1_pass_len", 32'(n), IN_PIX);
        checkOutput("c1_done_idx", 32'(crop_idx), 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c2_idx", 32'(crop_idx), 2);
        checkOutput("c2_y_data", 32'(bus0.crop_Y1_TDATA), 52);
        checkOutput("c2_x_data", 32'(bus0.crop_X1_TDATA), 112);

        // Third pass: random readies and random output fires
        n = 0;
        while ((bus0.crop_Y1_TVALID || bus0.crop_X1_TVALID) && n < 200) begin
            bus0.crop_Y1_TREADY = 1'($urandom_range(0, 1));
            bus0.crop_X1_TREADY = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus0.crop_Y1_TREADY = 0; bus0.crop_X1_TREADY = 0;
        checkOutput("c2_issue_bound", 32'(n < 200), 1);
        n = 0; got = 0;
        while (!got && n < 40000) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            n++;
            if (crop_done) got = 1;
        end
        checkOutput("c2_done_seen", 32'(got), 1);
        checkOutput("c2_min_len", 32'(n >= IN_PIX), 1);
        tick();
        checkOutput("all_done_pulse", 32'(all_done), 1);
        checkOutput("all_done_busy", 32'(busy), 0);
        tick();
        checkOutput("all_done_cleared", 32'(all_done), 0);
        checkOutput("hs_y_count", 32'(yLog.size()), 3);
        checkOutput("hs_x_count", 32'(xLog.size()), 3);
        for (int i = 0; i < 3 && i < yLog.size() && i < xLog.size(); i++) begin
            checkOutput("hs_y_value", 32'(yLog[i]), 32'(expY[i]));
            checkOutput("hs_x_value", 32'(xLog[i]), 32'(expX[i]));
        end
        checkOutput("done_count", 32'(doneCount), 3);
        checkOutput("all_count", 32'(allCount), 1);
        checkOutput("no_cfg_err", 32'(cfg_err), 0);

        // Reset in the middle of the second pass of a fresh run
        start = 1; tick(); start = 0;
        bus0.crop_Y1_TREADY = 1; bus0.crop_X1_TREADY = 1; tick();
        bus0.crop_Y1_TREADY = 0; bus0.crop_X1_TREADY = 0;
        runPass("r0_done_seen", n);
        applyStimulus(1'b0, 1'b0);
        checkOutput("r1_idx", 32'(crop_idx), 1);
        bus0.crop_Y1_TREADY = 1; bus0.crop_X1_TREADY = 1; tick();
        bus0.crop_Y1_TREADY = 0; bus0.crop_X1_TREADY = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("r1_busy", 32'(busy), 1);
        reset = 0;
        #1;
        checkAllZero("abort");
        tick();
        reset = 1;
        start = 1; tick(); start = 0;
        checkOutput("reload_start_busy", 32'(busy), 0);
        checkOutput("reload_start_valid", 32'(bus0.crop_Y1_TVALID), 0);
        checkOutput("reload_ready", 32'(bus0.cfg_TREADY), 1);
        loadCoord(10'd10, 10'd20);
        loadCoord(10'd30, 10'd40);
        loadCoord(10'd50, 10'd100);
        start = 1; tick(); start = 0;
        checkOutput("reload_y_data", 32'(bus0.crop_Y1_TDATA), 10);
        checkOutput("reload_x_data", 32'(bus0.crop_X1_TDATA), 20);
        checkOutput("reload_idx", 32'(crop_idx), 0);

        // Single-entry table with an out-of-range origin
        reset1 = 1;
        n = 0;
        bus1.cfg_TDATA = {10'd60, 10'd130}; bus1.cfg_TVALID = 1;
        while (!bus1.cfg_TREADY && n < 20) begin
            tick();
            n++;
        end
        checkOutput("clamp_ready_wait", 32'(n < 20), 1);
        tick();
        bus1.cfg_TVALID = 0;
        checkOutput("clamp_err", 32'(cfg_err1), 1);
        checkOutput("clamp_full", 32'(bus1.cfg_TREADY), 0);
        start1 = 1; tick(); start1 = 0;
        checkOutput("clamp_valid", 32'(bus1.crop_Y1_TVALID), 1);
        checkOutput("clamp_y_data", 32'(bus1.crop_Y1_TDATA), 52);
        checkOutput("clamp_x_data", 32'(bus1.crop_X1_TDATA), 112);
        checkOutput("clamp_idx", 32'(crop_idx1), 0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("clamp_err_sticky", 32'(cfg_err1), 1);
        reset1 = 0;
        #1;
        checkOutput("clamp_err_reset", 32'(cfg_err1), 0);
        checkOutput("clamp_valid_reset", 32'(bus1.crop_Y1_TVALID), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
